// File: rtl/fbmem_pkg.sv
// rtl/fbmem_pkg.sv - shared bus command codes, responder states and burst-length helper
package fbmem_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE    = 3'b000,
    CMD_WR_DATA = 3'b001,
    CMD_RD_REQ  = 3'b010,
    CMD_RD_DATA = 3'b011,
    CMD_WR_REQ  = 3'b100,
    CMD_WR_RESP = 3'b101
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_WR_BID  = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_BID  = 3'd4,
    ST_RD_DATA = 3'd5
  } state_e;

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_BID  = 2'b01;

  function automatic logic [3:0] len_to_beats(input logic [1:0] len);
    return 4'd1 << len;
  endfunction

endpackage

// File: rtl/fb_mem_responder_if.sv
// rtl/fb_mem_responder_if.sv - bus-side request inputs and arbitrated response outputs
interface fb_mem_responder_if;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic [3:0]  srcin;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;

  modport slave (
    input  selin, cmdin, lenin, addrdatain, srcin, ackin,
    output reqout, reqtar, cmdout, lenout, addrdataout
  );

  modport master (
    output selin, cmdin, lenin, addrdatain, srcin, ackin,
    input  reqout, reqtar, cmdout, lenout, addrdataout
  );
endinterface

// File: rtl/fbmem_ram.sv
// rtl/fbmem_ram.sv - 256x32 word store, synchronous write, combinational read, contents survive reset
module fbmem_ram (
  input  logic        clk,
  input  logic        i_we,
  input  logic [7:0]  i_widx,
  input  logic [31:0] i_wdata,
  input  logic [7:0]  i_ridx,
  output logic [31:0] o_rdata
);

  logic [31:0] r_mem [0:255];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/fb_mem_responder.sv
// rtl/fb_mem_responder.sv - bus memory slave: accepts write/read bursts, bids for the bus, returns responses
module fb_mem_responder
  import fbmem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  fb_mem_responder_if.slave bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_addr;
  logic [1:0]  r_len;
  logic [3:0]  r_src;
  logic [3:0]  r_cnt;
  logic [7:0]  r_idx;

  logic [1:0]  r_reqout;
  logic [3:0]  r_reqtar;
  logic [2:0]  r_cmdout;
  logic [1:0]  r_lenout;
  logic [31:0] r_ad;
  logic [1:0]  w_reqout_nxt;
  logic [3:0]  w_reqtar_nxt;
  logic [2:0]  w_cmdout_nxt;
  logic [1:0]  w_lenout_nxt;
  logic [31:0] w_ad_nxt;

  logic        w_req_wr;
  logic        w_req_rd;
  logic        w_wr_beat;
  logic        w_rd_beat;
  logic        w_last;
  logic [31:0] w_rdata;

  assign w_req_wr  = bus.selin && (bus.cmdin == CMD_WR_REQ);
  assign w_req_rd  = bus.selin && (bus.cmdin == CMD_RD_REQ);
  assign w_wr_beat = (r_state == ST_WR_DATA) && bus.selin && (bus.cmdin == CMD_WR_DATA);
  assign w_rd_beat = (r_state == ST_RD_DATA);
  assign w_last    = (r_cnt == (len_to_beats(r_len) - 4'd1));

  fbmem_ram u_ram (
    .clk     (clk),
    .i_we    (w_wr_beat),
    .i_widx  (r_idx),
    .i_wdata (bus.addrdatain),
    .i_ridx  (r_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are a registered image of the current state's activity, so they trail the state by one edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_reqout_nxt = REQ_NONE;
    w_reqtar_nxt = 4'd0;
    w_cmdout_nxt = CMD_IDLE;
    w_lenout_nxt = 2'b00;
    w_ad_nxt     = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_wr) begin
          w_state_nxt = ST_WR_DATA;
        end else if (w_req_rd) begin
          w_state_nxt = ST_RD_BID;
        end
      end
      ST_WR_DATA: begin
        if (w_wr_beat && w_last) begin
          w_state_nxt = ST_WR_BID;
        end
      end
      ST_WR_BID: begin
        w_reqout_nxt = REQ_BID;
        w_reqtar_nxt = r_src;
        if (bus.ackin) begin
          w_state_nxt = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        w_reqout_nxt = REQ_BID;
        w_reqtar_nxt = r_src;
        w_cmdout_nxt = CMD_WR_RESP;
        w_lenout_nxt = r_len;
        w_ad_nxt     = r_addr;
        w_state_nxt  = ST_IDLE;
      end
      ST_RD_BID: begin
        w_reqout_nxt = REQ_BID;
        w_reqtar_nxt = r_src;
        if (bus.ackin) begin
          w_state_nxt = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        w_reqout_nxt = REQ_BID;
        w_reqtar_nxt = r_src;
        w_cmdout_nxt = CMD_RD_DATA;
        w_lenout_nxt = r_len;
        w_ad_nxt     = w_rdata;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= 32'd0;
      r_len  <= 2'b00;
      r_src  <= 4'd0;
      r_cnt  <= 4'd0;
      r_idx  <= 8'd0;
    end else if ((r_state == ST_IDLE) && (w_req_wr || w_req_rd)) begin
      r_addr <= bus.addrdatain;
      r_len  <= bus.lenin;
      r_src  <= bus.srcin;
      r_cnt  <= 4'd0;
      r_idx  <= bus.addrdatain[9:2];
    end else if (w_wr_beat || w_rd_beat) begin
      r_cnt  <= w_last ? 4'd0 : (r_cnt + 4'd1);
      r_idx  <= r_idx + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reqout <= REQ_NONE;
      r_reqtar <= 4'd0;
      r_cmdout <= CMD_IDLE;
      r_lenout <= 2'b00;
      r_ad     <= 32'd0;
    end else begin
      r_reqout <= w_reqout_nxt;
      r_reqtar <= w_reqtar_nxt;
      r_cmdout <= w_cmdout_nxt;
      r_lenout <= w_lenout_nxt;
      r_ad     <= w_ad_nxt;
    end
  end

  assign bus.reqout      = r_reqout;
  assign bus.reqtar      = r_reqtar;
  assign bus.cmdout      = r_cmdout;
  assign bus.lenout      = r_lenout;
  assign bus.addrdataout = r_ad;

endmodule

// File: tb/tb_fb_mem_responder.sv
// tb/tb_fb_mem_responder.sv - directed transactions against a word-array model of the responder
module tb_fb_mem_responder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fb_mem_responder_if bus();

  fb_mem_responder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [31:0] model_mem [0:255];
  logic [31:0] wbuf [0:7];
  logic [31:0] lit_q [$];

  logic [1:0]  e_reqout;
  logic [3:0]  e_reqtar;
  logic [2:0]  e_cmdout;
  logic [1:0]  e_lenout;
  logic [31:0] e_ad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("reqout", 32'(bus.reqout), 32'(e_reqout));
      chk("reqtar", 32'(bus.reqtar), 32'(e_reqtar));
      chk("cmdout", 32'(bus.cmdout), 32'(e_cmdout));
      chk("lenout", 32'(bus.lenout), 32'(e_lenout));
      chk("addrdataout", bus.addrdataout, e_ad);
    end
  end

  task automatic set_exp(input logic [1:0] rq, input logic [3:0] tar, input logic [2:0] cmd,
                         input logic [1:0] ln, input logic [31:0] ad);
    e_reqout = rq;
    e_reqtar = tar;
    e_cmdout = cmd;
    e_lenout = ln;
    e_ad     = ad;
  endtask

  task automatic exp_idle();
    set_exp(2'b00, 4'd0, 3'b000, 2'b00, 32'd0);
  endtask

  task automatic drive(input logic sel, input logic [2:0] cmd, input logic [1:0] len,
                       input logic [31:0] ad, input logic [3:0] src, input logic ack);
    bus.selin      = sel;
    bus.cmdin      = cmd;
    bus.lenin      = len;
    bus.addrdatain = ad;
    bus.srcin      = src;
    bus.ackin      = ack;
  endtask

  task automatic drive_idle(input logic ack);
    drive(1'b0, 3'b000, 2'b00, 32'd0, 4'd0, ack);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write burst of wbuf[0..N-1]; an idle cycle precedes beat stall_at; grant arrives after ack_delay bid cycles.
  task automatic wr(input logic [31:0] addr, input logic [1:0] len, input logic [3:0] src,
                    input int stall_at, input int ack_delay);
    int n;
    logic [7:0] ix;
    n = 1 << len;
    drive(1'b1, 3'b100, len, addr, src, 1'b0);
    tick(); exp_idle();
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        drive(1'b1, 3'b000, 2'b00, 32'hFFFF_FFFF, 4'd0, 1'b0);
        tick(); exp_idle();
      end
      drive(1'b1, 3'b001, 2'b00, wbuf[k], 4'd0, 1'b0);
      tick(); exp_idle();
      ix = addr[9:2] + 8'(k);
      model_mem[ix] = wbuf[k];
    end
    for (int d = 0; d < ack_delay; d++) begin
      drive_idle(1'b0);
      tick(); set_exp(2'b01, src, 3'b000, 2'b00, 32'd0);
    end
    drive_idle(1'b1);
    tick(); set_exp(2'b01, src, 3'b000, 2'b00, 32'd0);
    drive_idle(1'b0);
    tick(); set_exp(2'b01, src, 3'b101, len, addr);
    chk("wresp_cmd_lit", 32'(bus.cmdout), 32'h5);
    chk("wresp_tar_lit", 32'(bus.reqtar), 32'(src));
    tick(); exp_idle();
  endtask

  // Read burst; a stray read request is injected on beat inject_at; reset pulses after beat rst_beat.
  task automatic rd(input logic [31:0] addr, input logic [1:0] len, input logic [3:0] src,
                    input int ack_delay, input int inject_at, input int rst_beat);
    int n;
    logic [7:0] ix;
    n = 1 << len;
    drive(1'b1, 3'b010, len, addr, src, 1'b0);
    tick(); exp_idle();
    for (int d = 0; d < ack_delay; d++) begin
      drive_idle(1'b0);
      tick(); set_exp(2'b01, src, 3'b000, 2'b00, 32'd0);
      chk("grant_wait_reqout_lit", 32'(bus.reqout), 32'h1);
      chk("grant_wait_cmdout_lit", 32'(bus.cmdout), 32'h0);
    end
    drive_idle(1'b1);
    tick(); set_exp(2'b01, src, 3'b000, 2'b00, 32'd0);
    for (int k = 0; k < n; k++) begin
      if (k == inject_at) drive(1'b1, 3'b010, 2'b11, 32'h0000_0000, 4'hF, 1'b1);
      else drive_idle(1'b0);
      tick();
      ix = addr[9:2] + 8'(k);
      set_exp(2'b01, src, 3'b011, len, model_mem[ix]);
      if (lit_q.size() > 0) chk("rd_beat_lit", bus.addrdataout, lit_q.pop_front());
      if (k == rst_beat) begin
        reset_n = 1'b0;
        exp_idle();
        #1;
        chk("rst_reqout_lit", 32'(bus.reqout), 32'h0);
        chk("rst_cmdout_lit", 32'(bus.cmdout), 32'h0);
        chk("rst_data_lit", bus.addrdataout, 32'h0);
        drive_idle(1'b0);
        tick(); exp_idle();
        reset_n = 1'b1;
        lit_q.delete();
        return;
      end
    end
    drive_idle(1'b0);
    tick(); exp_idle();
    tick(); exp_idle();
    tick(); exp_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive_idle(1'b0);
    exp_idle();
    chk_en = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;

    // single write then read at word 0x04, accepted on the first edge after reset
    wbuf[0] = 32'hA5A5_A5A5;
    wr(32'h0000_0010, 2'b00, 4'd3, -1, 0);
    lit_q.push_back(32'hA5A5_A5A5);
    rd(32'h0000_0010, 2'b00, 4'd3, 0, -1, -1);

    // ignored traffic in IDLE
    drive(1'b0, 3'b100, 2'b00, 32'h40, 4'd1, 1'b0); tick(); exp_idle();
    drive(1'b0, 3'b010, 2'b00, 32'h40, 4'd1, 1'b0); tick(); exp_idle();
    drive(1'b1, 3'b001, 2'b00, 32'h40, 4'd1, 1'b1); tick(); exp_idle();
    drive(1'b1, 3'b011, 2'b00, 32'h40, 4'd1, 1'b0); tick(); exp_idle();
    drive(1'b1, 3'b101, 2'b00, 32'h40, 4'd1, 1'b1); tick(); exp_idle();
    drive_idle(1'b1); tick(); exp_idle();

    // 4-beat burst wrapping FE, FF, 00, 01
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    wr(32'h0000_03F8, 2'b10, 4'd5, -1, 2);
    lit_q.push_back(32'h11); lit_q.push_back(32'h22);
    lit_q.push_back(32'h33); lit_q.push_back(32'h44);
    rd(32'h0000_03F8, 2'b10, 4'd5, 0, -1, -1);
    lit_q.push_back(32'h33);
    rd(32'h0000_0000, 2'b00, 4'd1, 0, -1, -1);
    lit_q.push_back(32'h22);
    rd(32'hFFFF_FC00 | 32'h3FE, 2'b00, 4'd1, 0, -1, -1);

    // grant held off for 5 cycles
    lit_q.push_back(32'hA5A5_A5A5);
    rd(32'h0000_0010, 2'b00, 4'd7, 5, -1, -1);

    // data stall between beats
    wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'hCAFE_F00D;
    wr(32'h0000_0080, 2'b01, 4'd2, 1, 0);
    lit_q.push_back(32'hDEAD_BEEF); lit_q.push_back(32'hCAFE_F00D);
    rd(32'h0000_0080, 2'b01, 4'd2, 0, -1, -1);

    // 8-beat burst, stray request during read data, then reset on beat 2
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
    wr(32'h0000_0200, 2'b11, 4'd9, -1, 1);
    rd(32'h0000_0200, 2'b11, 4'd9, 0, 1, -1);
    rd(32'h0000_0200, 2'b11, 4'd9, 0, -1, 1);
    for (int k = 0; k < 8; k++) lit_q.push_back(32'h1000_0000 + 32'(k) * 32'h0101_0101);
    rd(32'h0000_0200, 2'b11, 4'd4, 0, -1, -1);
    lit_q.push_back(32'hA5A5_A5A5);
    rd(32'h0000_0010, 2'b00, 4'd3, 1, -1, -1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_mem_responder.md
FB_MEM_RESPONDER -- requirements
Module: fb_mem_responder

Interface
REQ-001 The block SHALL use reset reset_n, asynchronous, active-low, and clock clk.
REQ-002 Ports SHALL be exactly as follows.
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- selin  in  1  this device addressed on bus
- cmdin  in  3  bus command: 000 idle, 001 write data, 010 read request, 011 read data, 100 write request, 101 write response
- lenin  in  2  burst length code: 00=1, 01=2, 10=4, 11=8 beats
- addrdatain  in  32  address (request phase) / data (data phase)
- srcin  in  4  requester ID, valid with a request
- ackin  in  1  arbiter grant
- reqout  out  2  arbiter bid: 00 none, 01 bid
- reqtar  out  4  response target, the latched srcin
- cmdout  out  3  response command
- lenout  out  2  response length code, the latched lenin
- addrdataout  out  32  response address/data

Function
REQ-003 States SHALL be IDLE, WR_DATA, WR_BID, WR_RESP, RD_BID and RD_DATA.
REQ-004 In IDLE with selin=1 and cmdin=100, the block SHALL latch addrdatain, lenin and srcin, then go to WR_DATA.
REQ-005 In IDLE with selin=1 and cmdin=010, the block SHALL latch addrdatain, lenin and srcin, then go to RD_BID.
REQ-006 In IDLE, any other command, or selin=0, SHALL be ignored.
REQ-007 Requests arriving in any state other than IDLE SHALL be ignored; there is no queueing.
REQ-008 Beat count SHALL be N = 1<<len. A 4-bit beat counter SHALL count from 0 to N-1.
REQ-009 Word index SHALL be addr[9:2], 8 bits. Bits [1:0] and [31:10] SHALL be ignored.
REQ-010 The word index SHALL increment by 1 per beat and wrap 0xFF->0x00.
REQ-011 In WR_DATA, each cycle with selin=1 and cmdin=001 SHALL write addrdatain to the current index and advance the counter.
REQ-012 In WR_DATA, cycles without that condition SHALL stall: no write, no advance.
REQ-013 After beat N-1 is written, the block SHALL go to WR_BID.
REQ-014 In WR_BID, reqout SHALL be 01 and reqtar SHALL be the latched srcin.
REQ-015 In WR_BID, ackin=1 SHALL cause a transition to WR_RESP.
REQ-016 In WR_RESP, for exactly one cycle, the block SHALL drive cmdout=101, addrdataout=latched start address and lenout=latched len, with reqout held at 01; it SHALL then return to IDLE.
REQ-017 In RD_BID, reqout SHALL be 01 and reqtar SHALL be the latched srcin.
REQ-018 In RD_BID, ackin=1 SHALL cause a transition to RD_DATA.
REQ-019 In RD_DATA, the block SHALL drive N consecutive cycles of cmdout=011 with addrdataout=mem[index]. Beat k SHALL be from start index + k (mod 256).
REQ-020 In RD_DATA, reqout SHALL stay 01 through the last beat, and the block SHALL then return to IDLE.
REQ-021 Read latency SHALL be: ackin sampled high at edge G, first data beat registered valid from edge G+1.
REQ-022 Outputs SHALL be registered. When not driving a response, outputs SHALL be reqout=00, cmdout=000, lenout=00, addrdataout=0 and reqtar=0.
REQ-023 ackin SHALL be ignored outside WR_BID and RD_BID.
REQ-024 A read of a word never written SHALL return its undefined/initial content; the bench initialises memory before reading.
REQ-025 A write followed by a read of the same index SHALL return the new data; the write commits at its data edge.

Reset
REQ-026 reset_n=0 SHALL force IDLE, all outputs to 0, beat counter and latches to 0, at any time including mid-burst.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 After reset_n deasserts, the first request SHALL be accepted on the first clk edge.

Structure
REQ-029 A shared package fbmem_pkg SHALL hold the cmd enum (CMD_IDLE..CMD_WR_RESP), the state enum and the len-to-beats function.
REQ-030 Storage SHALL be a sub-module fbmem_ram: 256x32, synchronous write, asynchronous read, 8-bit index, no reset.

Verification
REQ-031 Single write then read: write request addr 0x10 len 00 src 3, data 0xA5A5A5A5. Required response: WR_RESP cycle with cmdout=101, addrdataout=0x10, reqtar=3. Then read 0x10 len 00 with ackin, giving one beat with cmdout=011, data 0xA5A5A5A5.
REQ-032 Burst with wrap: write 4 words 0x11..0x44 at addr 0x3F8 (index 0xFE). Index sequence SHALL be FE, FF, 00, 01. Reading addr 0x3F8 len 10 SHALL return 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles from G+1.
REQ-033 Grant delay: read request, then ackin held low for 5 cycles. reqout SHALL stay 01 and cmdout SHALL stay 000 throughout. The first beat SHALL appear one cycle after ackin rises.
REQ-034 Data stall: write len 01 with one idle cycle (cmdin=000) inserted between the data beats. Both words SHALL be stored correctly and the counter SHALL not advance on the idle cycle.
REQ-035 Busy drop and reset: a read request issued during RD_DATA SHALL be ignored, with no second burst. Pulsing reset_n low on the 2nd beat of an 8-beat read SHALL give outputs 0 at once and IDLE state, and memory SHALL still read back the earlier data.
